// File: rtl/conv_mult_arbiter.sv
// conv_mult_arbiter
// Shares one multiplier lane array between NUM_REQ convolution controllers.
// Round-robin arbitration with burst lock; a tag pipeline that runs in step
// with the multiplier routes each product back to the controller that issued it.

module conv_mult_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int BIT_LENGTH   = 16,
    parameter int PORTS        = 3,
    parameter int BURST_LEN    = 3,
    parameter int MULT_LATENCY = 2
) (
    input  logic                               Clk,
    input  logic                               Rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ-1:0]                 req_last,
    input  logic [NUM_REQ*PORTS*BIT_LENGTH-1:0] req_a,
    input  logic [NUM_REQ*PORTS*BIT_LENGTH-1:0] req_b,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [PORTS*BIT_LENGTH-1:0]        mult_a,
    output logic [PORTS*BIT_LENGTH-1:0]        mult_b,
    output logic [PORTS-1:0]                   mult_start,
    input  logic [PORTS*2*BIT_LENGTH-1:0]      mult_result,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [PORTS*2*BIT_LENGTH-1:0]      rsp_data,
    output logic [$clog2(NUM_REQ)-1:0]         grant_id,
    output logic                               busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam int OP_W  = PORTS * BIT_LENGTH;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    logic [0:0]      state;
    logic [ID_W-1:0] rr_ptr;
    logic [CNT_W-1:0] beat_cnt;
    logic [ID_W-1:0] pick_id;
    logic            pick_found;
    logic            accept;
    logic            burst_end;
    logic            issue_vld;
    logic [ID_W-1:0] issue_id;
    logic [MULT_LATENCY-1:0] tag_vld;
    logic [ID_W-1:0] tag_id [MULT_LATENCY];

    // Round-robin search: first valid requester at or above rr_ptr, wrapping around
    always_comb begin
        pick_found = 1'b0;
        pick_id    = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // A beat is taken only from the locked requester; the burst closes on last or on the beat limit
    always_comb begin
        accept    = (state == BURST) && req_valid[grant_id];
        burst_end = accept && (req_last[grant_id] || (beat_cnt == CNT_W'(BURST_LEN - 1)));
    end

    // Ready is asserted only toward the granted requester while a burst is open
    always_comb begin
        req_ready = '0;
        if (state == BURST) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Arbitration FSM: IDLE picks a winner, BURST holds it until the burst closes
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            grant_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_id;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (burst_end) begin
                            state <= IDLE;
                            if (int'(grant_id) == NUM_REQ - 1) begin
                                rr_ptr <= '0;
                            end else begin
                                rr_ptr <= grant_id + 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Issue stage: register the accepted beat's operands and remember who sent it
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            issue_vld <= 1'b0;
            issue_id  <= '0;
            mult_a    <= '0;
            mult_b    <= '0;
        end else begin
            issue_vld <= accept;
            if (accept) begin
                issue_id <= grant_id;
                mult_a   <= req_a[int'(grant_id) * OP_W +: OP_W];
                mult_b   <= req_b[int'(grant_id) * OP_W +: OP_W];
            end
        end
    end

    assign mult_start = {PORTS{issue_vld}};

    // Tag pipeline: shifts alongside the multiplier so the tail tag lines up with its product
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tag_vld <= '0;
            for (int k = 0; k < MULT_LATENCY; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_vld[0] <= issue_vld;
            tag_id[0]  <= issue_id;
            for (int k = 1; k < MULT_LATENCY; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
        end
    end

    // Retire: strobe the owner of the tail tag and pass the product straight through
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (tag_vld[MULT_LATENCY-1]) begin
            rsp_valid[tag_id[MULT_LATENCY-1]] = 1'b1;
            rsp_data = mult_result;
        end
    end

    assign busy = (state != IDLE) || issue_vld || (|tag_vld);

endmodule
